mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares a single memory bus between the instruction-fetch port and the data-access port of the CPU datapath, for the unified-memory (von Neumann) build variant.
- Accepts requests on both ports and picks one owner per transaction. It drives the memory bus with registered signals and honours the bus waitrequest.
- Returns a one-cycle acknowledge with read data to the winning port.
- A timeout counter detects bus hangs and reports them through a sticky error flag.

Parameters:
- FAIR, 1: 1 = alternate winner on contention (last-grant toggle); 0 = data port always wins.
- TIMEOUT, 255: maximum consecutive waitrequest cycles before abort; 8-bit counter; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- instr_read  in  1  fetch request; held until instr_ack
- instr_addr  in  32  fetch byte address; stable while instr_read=1
- instr_rdata  out  32  fetched word; valid only while instr_ack=1
- instr_ack  out  1  one-cycle completion pulse for fetch
- data_read  in  1  data load request
- data_write  in  1  data store request
- data_addr  in  32  data byte address
- data_writedata  in  32  store data
- data_byteenable  in  4  store/load byte lanes
- data_rdata  out  32  load data; valid only while data_ack=1
- data_ack  out  1  one-cycle completion pulse for data
- mem_address  out  32  bus address (registered)
- mem_read  out  1  bus read strobe (registered)
- mem_write  out  1  bus write strobe (registered)
- mem_writedata  out  32  bus write data (registered)
- mem_byteenable  out  4  bus byte lanes (registered)
- mem_readdata  in  32  bus read data; valid in the cycle waitrequest=0
- mem_waitrequest  in  1  bus stall; transaction completes at the edge where mem_waitrequest=0 with a strobe high
- bus_error  out  1  sticky; set on timeout, cleared only by reset

Behaviour:
- **Reset (reset=0, async):**
  - state=IDLE; every output = 0; last_grant=INSTR, so data wins the first contention.
  - Timeout counter = 0. Any in-flight transaction is dropped, with no ack.
- **States:** IDLE, BUS_I, BUS_D, ACK.
- **IDLE:**
  - Samples requests. A data request is data_read|data_write.
  - Only one request: grant it.
  - Both requests:
    - FAIR=0: data wins.
    - FAIR=1: the port not in last_grant wins.
  - On grant:
    - Register the winner's address, strobe, writedata and byteenable into the mem_* outputs.
    - Instruction grant: mem_read=1, mem_byteenable=4'b1111, mem_writedata=0.
    - data_write and data_read both high: treated as a write (mem_write=1, mem_read=0).
    - Update last_grant; go to BUS_I or BUS_D.
- **BUS_I / BUS_D:**
  - mem_* outputs stay constant while mem_waitrequest=1; the counter increments each such cycle.
  - Edge with mem_waitrequest=0:
    - Deassert mem_read/mem_write.
    - Capture mem_readdata into the granted port's rdata register (writes capture nothing; rdata holds its old value).
    - Pulse the port's ack next cycle; go to ACK.
  - Timeout (TIMEOUT≠0 and counter reaches TIMEOUT):
    - Deassert strobes, set bus_error, go to ACK with the ack pulse.
    - Read data is forced to 32'h0000_0000.
- **ACK:**
  - Exactly one of instr_ack/data_ack =1 for exactly one cycle; counter cleared.
  - Next state is IDLE.
  - Requesters drop their request in the ack cycle. A request still high when back in IDLE is a new transaction.
- **Throughput and latency:**
  - Minimum latency is request high in IDLE → ack 3 cycles later, with 0 wait states: grant edge, completion edge, ACK.
  - Peak throughput is one transaction per 3 cycles.
- **Request stability:** requests and addresses that change while not in IDLE are ignored; the losing port keeps waiting with no ack.
- **Strobes:** mem_read and mem_write are never both 1. Strobes are 0 in IDLE and ACK.
- **Timeout counter:** saturates at 8 bits and never wraps.
- **Starvation:** with FAIR=1 and both ports continuously requesting, grants strictly alternate (D,I,D,I…). With FAIR=0, instruction may starve; this is intended.

Test Plan:
- Single fetch, 0 wait states: instr_read=1, instr_addr=32'hBFC0_0000, mem_readdata=32'h2408_0005 → mem_read=1 with mem_address=BFC00000 for 1 cycle; instr_ack pulse 3 cycles after request with instr_rdata=32'h2408_0005; data_ack stays 0.
- Store with 2 wait states: data_write=1, addr=32'h0000_1004, writedata=32'hDEAD_BEEF, byteenable=4'b0011 → mem_write held 3 cycles with stable address/data/byteenable; data_ack 5 cycles after request; mem_read never 1.
- Contention, FAIR=1: both ports request continuously for 4 transactions after reset → grant order D,I,D,I. Rerun with FAIR=0 → D,D,D,D and no instr_ack.
- Timeout: TIMEOUT=4, data_read, mem_waitrequest stuck 1 → strobe drops after 4 wait cycles; data_ack pulses with data_rdata=0; bus_error=1 and remains 1 through later good transactions.
- Reset mid-transaction: assert reset=0 asynchronously in BUS_I between edges → all outputs 0 immediately with no ack. After release, a pending data_read is granted first.
- Read+write both high: data_read=data_write=1 → mem_write=1, mem_read=0.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one memory bus between the instruction-fetch and data-access ports.
// Registered bus outputs, one-cycle acks, and a saturating wait counter with sticky timeout error.
module mem_bus_arbiter #(
    parameter bit          FAIR    = 1'b1,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_read,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr_rdata,
    output logic        instr_ack,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_writedata,
    input  logic [3:0]  data_byteenable,
    output logic [31:0] data_rdata,
    output logic        data_ack,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_byteenable,
    input  logic [31:0] mem_readdata,
    input  logic        mem_waitrequest,
    output logic        bus_error
);

    typedef enum logic [1:0] {StIdle, StBusI, StBusD, StAck} state_e;

    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);
    localparam bit         TimeoutEn  = (TIMEOUT != 0);

    state_e      state_q, state_d;
    logic        last_data_q, last_data_d;  // 1: most recent grant went to the data port
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] mem_writedata_q, mem_writedata_d;
    logic [3:0]  mem_byteenable_q, mem_byteenable_d;
    logic [31:0] instr_rdata_q, instr_rdata_d;
    logic [31:0] data_rdata_q, data_rdata_d;
    logic        instr_ack_q, instr_ack_d;
    logic        data_ack_q, data_ack_d;
    logic        bus_error_q, bus_error_d;

    logic        data_req;
    logic        grant_data;
    logic [7:0]  wait_cnt_inc;

    always_comb begin
        state_d          = state_q;
        last_data_d      = last_data_q;
        wait_cnt_d       = wait_cnt_q;
        mem_address_d    = mem_address_q;
        mem_read_d       = mem_read_q;
        mem_write_d      = mem_write_q;
        mem_writedata_d  = mem_writedata_q;
        mem_byteenable_d = mem_byteenable_q;
        instr_rdata_d    = instr_rdata_q;
        data_rdata_d     = data_rdata_q;
        instr_ack_d      = 1'b0;
        data_ack_d       = 1'b0;
        bus_error_d      = bus_error_q;

        data_req     = data_read | data_write;
        grant_data   = data_req & (~instr_read | ~FAIR | ~last_data_q);
        wait_cnt_inc = (wait_cnt_q == 8'hff) ? wait_cnt_q : wait_cnt_q + 8'd1;

        unique case (state_q)
            StIdle: begin
                wait_cnt_d = '0;
                if (grant_data) begin
                    mem_address_d    = data_addr;
                    // A simultaneous read and write is treated as a write.
                    mem_write_d      = data_write;
                    mem_read_d       = data_read & ~data_write;
                    mem_writedata_d  = data_writedata;
                    mem_byteenable_d = data_byteenable;
                    last_data_d      = 1'b1;
                    state_d          = StBusD;
                end else if (instr_read) begin
                    mem_address_d    = instr_addr;
                    mem_read_d       = 1'b1;
                    mem_write_d      = 1'b0;
                    mem_writedata_d  = '0;
                    mem_byteenable_d = 4'b1111;
                    last_data_d      = 1'b0;
                    state_d          = StBusI;
                end
            end
            StBusI, StBusD: begin
                if (!mem_waitrequest) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = StAck;
                    if (state_q == StBusI) begin
                        instr_rdata_d = mem_readdata;
                        instr_ack_d   = 1'b1;
                    end else begin
                        if (mem_read_q) begin
                            data_rdata_d = mem_readdata;
                        end
                        data_ack_d = 1'b1;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_inc;
                    if (TimeoutEn && (wait_cnt_inc >= TimeoutCnt)) begin
                        mem_read_d  = 1'b0;
                        mem_write_d = 1'b0;
                        bus_error_d = 1'b1;
                        state_d     = StAck;
                        if (state_q == StBusI) begin
                            instr_rdata_d = '0;
                            instr_ack_d   = 1'b1;
                        end else begin
                            data_rdata_d = '0;
                            data_ack_d   = 1'b1;
                        end
                    end
                end
            end
            StAck: begin
                wait_cnt_d = '0;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= StIdle;
            last_data_q      <= 1'b0;
            wait_cnt_q       <= '0;
            mem_address_q    <= '0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_writedata_q  <= '0;
            mem_byteenable_q <= '0;
            instr_rdata_q    <= '0;
            data_rdata_q     <= '0;
            instr_ack_q      <= 1'b0;
            data_ack_q       <= 1'b0;
            bus_error_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            last_data_q      <= last_data_d;
            wait_cnt_q       <= wait_cnt_d;
            mem_address_q    <= mem_address_d;
            mem_read_q       <= mem_read_d;
            mem_write_q      <= mem_write_d;
            mem_writedata_q  <= mem_writedata_d;
            mem_byteenable_q <= mem_byteenable_d;
            instr_rdata_q    <= instr_rdata_d;
            data_rdata_q     <= data_rdata_d;
            instr_ack_q      <= instr_ack_d;
            data_ack_q       <= data_ack_d;
            bus_error_q      <= bus_error_d;
        end
    end

    assign mem_address    = mem_address_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_writedata  = mem_writedata_q;
    assign mem_byteenable = mem_byteenable_q;
    assign instr_rdata    = instr_rdata_q;
    assign data_rdata     = data_rdata_q;
    assign instr_ack      = instr_ack_q;
    assign data_ack       = data_ack_q;
    assign bus_error      = bus_error_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: transaction-timeline reference model, directed cases and random traffic.
module tb_mem_bus_arbiter;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_read = 1'b0, data_read = 1'b0, data_write = 1'b0;
    logic [31:0] instr_addr = '0, data_addr = '0, data_writedata = '0, mem_readdata = '0;
    logic [3:0]  data_byteenable = '0;
    logic        mem_waitrequest = 1'b0;
    logic [31:0] instr_rdata, data_rdata, mem_address, mem_writedata;
    logic        instr_ack, data_ack, mem_read, mem_write, bus_error;
    logic [3:0]  mem_byteenable;

    logic        nf_instr_read = 1'b0, nf_data_read = 1'b0, nf_data_write = 1'b0;
    logic [31:0] nf_mem_readdata = 32'h1234_5678;
    logic        nf_mem_waitrequest = 1'b0;
    logic [31:0] nf_instr_rdata, nf_data_rdata, nf_mem_address, nf_mem_writedata;
    logic        nf_instr_ack, nf_data_ack, nf_mem_read, nf_mem_write, nf_bus_error;
    logic [3:0]  nf_mem_byteenable;

    logic [136:0] main_outs;
    logic [136:0] nf_outs;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.FAIR(1'b1), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .instr_read(instr_read), .instr_addr(instr_addr), .instr_rdata(instr_rdata),
        .instr_ack(instr_ack), .data_read(data_read), .data_write(data_write),
        .data_addr(data_addr), .data_writedata(data_writedata),
        .data_byteenable(data_byteenable), .data_rdata(data_rdata), .data_ack(data_ack),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
        .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest), .bus_error(bus_error)
    );

    mem_bus_arbiter #(.FAIR(1'b0), .TIMEOUT(0)) dut_nf (
        .clk(clk), .reset(reset),
        .instr_read(nf_instr_read), .instr_addr(32'h0000_0100), .instr_rdata(nf_instr_rdata),
        .instr_ack(nf_instr_ack), .data_read(nf_data_read), .data_write(nf_data_write),
        .data_addr(32'h0000_2000), .data_writedata(32'h0), .data_byteenable(4'hf),
        .data_rdata(nf_data_rdata), .data_ack(nf_data_ack),
        .mem_address(nf_mem_address), .mem_read(nf_mem_read), .mem_write(nf_mem_write),
        .mem_writedata(nf_mem_writedata), .mem_byteenable(nf_mem_byteenable),
        .mem_readdata(nf_mem_readdata), .mem_waitrequest(nf_mem_waitrequest),
        .bus_error(nf_bus_error)
    );

    assign main_outs = {instr_rdata, instr_ack, data_rdata, data_ack, mem_address, mem_read,
                        mem_write, mem_writedata, mem_byteenable, bus_error};
    assign nf_outs   = {nf_instr_rdata, nf_instr_ack, nf_data_rdata, nf_data_ack, nf_mem_address,
                        nf_mem_read, nf_mem_write, nf_mem_writedata, nf_mem_byteenable,
                        nf_bus_error};

    int checks = 0;
    int failures = 0;

    // Requester-side intent (what the masters want right now).
    bit          i_req, d_rd, d_wr;
    logic [31:0] i_addr, d_addr, d_wd;
    logic [3:0]  d_be;

    // Reference timeline: a granted transaction occupies edges g_edge..comp_edge.
    int          edge_n, g_edge, comp_edge, free_at;
    bit          busy, s_data, timed_out, last_data, exp_err;
    bit          s_rd, s_wr;
    logic [31:0] s_addr, s_wd, comp_rd, exp_i_rd, exp_d_rd;
    logic [3:0]  s_be;
    int          fixed_waits, req_pct, model_acks;
    bit          force_en;
    logic [31:0] force_val;

    // Observations of the DUT.
    int          n_rd, n_wr, ack_cyc;
    int          ack_q[$];
    logic [31:0] obs_i_rd, obs_d_rd;
    logic        obs_err;

    task automatic check_eq(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        instr_read      = i_req;
        instr_addr      = i_addr;
        data_read       = d_rd;
        data_write      = d_wr;
        data_addr       = d_addr;
        data_writedata  = d_wd;
        data_byteenable = d_be;
    endtask

    task automatic model_reset();
        busy = 0; last_data = 0; exp_err = 0; exp_i_rd = '0; exp_d_rd = '0; free_at = 0;
    endtask

    task automatic clear_obs();
        n_rd = 0; n_wr = 0; ack_q.delete(); model_acks = 0;
    endtask

    task automatic cycle_step();
        int          cyc, nxt, w;
        bit          e_ia, e_da, e_rd, e_wr, ack_now;
        logic [31:0] new_rd;
        @(negedge clk);
        cyc = edge_n;
        e_ia = 0; e_da = 0; e_rd = 0; e_wr = 0; ack_now = 0;
        if (busy && cyc >= g_edge && cyc < comp_edge) begin
            e_rd = s_rd; e_wr = s_wr;
        end
        if (busy && cyc == comp_edge) begin
            ack_now = 1;
            model_acks++;
            if (timed_out) exp_err = 1;
            new_rd = timed_out ? 32'h0 : comp_rd;
            if (s_data) begin
                e_da = 1;
                if (timed_out || s_rd) exp_d_rd = new_rd;
            end else begin
                e_ia = 1;
                exp_i_rd = new_rd;
            end
        end
        check_eq("ctl{iack,dack,rd,wr,err}", {instr_ack, data_ack, mem_read, mem_write, bus_error},
                 {e_ia, e_da, e_rd, e_wr, exp_err});
        if (e_rd || e_wr) begin
            check_eq("mem_address", mem_address, s_addr);
            check_eq("mem_writedata", mem_writedata, s_wd);
            check_eq("mem_byteenable", mem_byteenable, s_be);
        end
        if (e_ia) check_eq("instr_rdata", instr_rdata, exp_i_rd);
        if (e_da) check_eq("data_rdata", data_rdata, exp_d_rd);

        if (mem_read) n_rd++;
        if (mem_write) n_wr++;
        if (instr_ack) begin ack_q.push_back(0); ack_cyc = cyc; obs_i_rd = instr_rdata; end
        if (data_ack) begin ack_q.push_back(1); ack_cyc = cyc; obs_d_rd = data_rdata; end
        obs_err = bus_error;

        // Masters drop in their ack cycle and may issue a fresh request afterwards.
        if (e_ia) i_req = 0;
        else if (!i_req && ($urandom_range(0, 99) < req_pct)) begin
            i_req = 1; i_addr = $urandom & 32'hffff_fffc;
        end
        if (e_da) begin d_rd = 0; d_wr = 0; end
        else if (!(d_rd || d_wr) && ($urandom_range(0, 99) < req_pct)) begin
            w = $urandom_range(0, 2);
            d_rd = (w != 1); d_wr = (w != 0);
            d_addr = $urandom; d_wd = $urandom; d_be = 4'($urandom);
        end
        if (ack_now) begin busy = 0; free_at = comp_edge + 2; end

        nxt = edge_n + 1;
        if (!busy && nxt >= free_at && (i_req || d_rd || d_wr)) begin
            s_data = (d_rd || d_wr) && (!i_req || !last_data);
            if (s_data) begin
                s_addr = d_addr; s_wr = d_wr; s_rd = d_rd && !d_wr; s_wd = d_wd; s_be = d_be;
            end else begin
                s_addr = i_addr; s_wr = 0; s_rd = 1; s_wd = '0; s_be = 4'hf;
            end
            last_data = s_data;
            w = (fixed_waits >= 0) ? fixed_waits : $urandom_range(0, 5);
            timed_out = (w >= int'(TO));
            comp_edge = timed_out ? nxt + int'(TO) : nxt + w + 1;
            g_edge = nxt;
            busy = 1;
        end
        mem_readdata = $urandom;
        if (busy && nxt > g_edge && nxt <= comp_edge) begin
            mem_waitrequest = timed_out || (nxt < comp_edge);
            if (!mem_waitrequest) begin
                if (force_en) mem_readdata = force_val;
                comp_rd = mem_readdata;
            end
        end else begin
            mem_waitrequest = 1'($urandom);
        end
        drive_inputs();
        @(posedge clk);
        edge_n++;
    endtask

    task automatic run_until_acks(input int n, input int bound);
        for (int k = 0; k < bound && ack_q.size() < n; k++) cycle_step();
        check_eq("ack_count", ack_q.size(), n);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 0;
        i_req = 0; d_rd = 0; d_wr = 0;
        drive_inputs();
        mem_waitrequest = 0;
        #1;
        check_eq("reset_outputs", main_outs, '0);
        check_eq("reset_outputs_nf", nf_outs, '0);
        @(posedge clk);
        edge_n++;
        #2 reset = 1;
        model_reset();
    endtask

    initial begin
        int req_cyc;
        int nf_i_acks, nf_d_acks, nf_errs;
        i_req = 0; d_rd = 0; d_wr = 0; i_addr = '0; d_addr = '0; d_wd = '0; d_be = '0;
        edge_n = 0; g_edge = 0; comp_edge = 0; fixed_waits = 0; req_pct = 0; force_en = 0;
        force_val = '0; ack_cyc = 0; obs_i_rd = '0; obs_d_rd = '0; obs_err = 0; s_data = 0;
        timed_out = 0; s_rd = 0; s_wr = 0; s_addr = '0; s_wd = '0; s_be = '0; comp_rd = '0;
        model_reset();
        clear_obs();
        do_reset();

        // Single fetch, zero wait states.
        clear_obs();
        force_en = 1; force_val = 32'h2408_0005;
        i_req = 1; i_addr = 32'hBFC0_0000;
        req_cyc = edge_n;
        run_until_acks(1, 20);
        check_eq("fetch_port", ack_q[0], 0);
        check_eq("fetch_latency", ack_cyc - req_cyc + 1, 3);
        check_eq("fetch_rdata", obs_i_rd, 32'h2408_0005);
        check_eq("fetch_rd_cycles", n_rd, 1);
        repeat (3) cycle_step();
        check_eq("fetch_single_ack", ack_q.size(), 1);

        // Store with two wait states.
        clear_obs();
        fixed_waits = 2;
        d_wr = 1; d_addr = 32'h0000_1004; d_wd = 32'hDEAD_BEEF; d_be = 4'b0011;
        req_cyc = edge_n;
        run_until_acks(1, 20);
        check_eq("store_port", ack_q[0], 1);
        check_eq("store_latency", ack_cyc - req_cyc + 1, 5);
        check_eq("store_wr_cycles", n_wr, 3);
        check_eq("store_rd_cycles", n_rd, 0);

        // Read and write together behave as a write.
        clear_obs();
        fixed_waits = 0;
        d_rd = 1; d_wr = 1; d_addr = 32'h0000_0040; d_wd = 32'h0BAD_F00D; d_be = 4'hf;
        run_until_acks(1, 20);
        check_eq("rw_wr_cycles", n_wr, 1);
        check_eq("rw_rd_cycles", n_rd, 0);

        // Timeout: waitrequest stuck high, then a good transaction keeps bus_error set.
        clear_obs();
        fixed_waits = 50;
        d_rd = 1; d_addr = 32'h0000_0080; d_be = 4'hf;
        run_until_acks(1, 30);
        check_eq("timeout_rd_cycles", n_rd, int'(TO));
        check_eq("timeout_rdata", obs_d_rd, 32'h0);
        check_eq("timeout_err", obs_err, 1'b1);
        fixed_waits = 1;
        i_req = 1; i_addr = 32'h0000_0200;
        run_until_acks(2, 20);
        check_eq("err_sticky", obs_err, 1'b1);

        // Asynchronous reset in the middle of a fetch.
        clear_obs();
        fixed_waits = 5;
        i_req = 1; i_addr = 32'h0000_0300;
        for (int k = 0; k < 10 && !(busy && edge_n > g_edge); k++) cycle_step();
        #2 reset = 0;
        #1 check_eq("async_reset_outputs", main_outs, '0);
        d_rd = 1; d_addr = 32'h0000_0400; d_be = 4'hf;
        #1 reset = 1;
        model_reset();
        clear_obs();
        fixed_waits = 0;
        run_until_acks(2, 20);
        check_eq("post_reset_first", ack_q[0], 1);
        check_eq("post_reset_second", ack_q[1], 0);

        // Fair contention from reset: D,I,D,I.
        do_reset();
        clear_obs();
        req_pct = 100;
        i_req = 1; d_rd = 1; d_addr = 32'h0000_0500; d_be = 4'hf;
        run_until_acks(4, 40);
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("fair_order%0d", k), ack_q[k], ((k % 2) == 0) ? 1 : 0);
        end
        req_pct = 0;
        repeat (12) cycle_step();

        // Random traffic with random wait states, including timeouts.
        clear_obs();
        fixed_waits = -1; force_en = 0; req_pct = 40;
        repeat (600) cycle_step();
        req_pct = 0;
        repeat (30) cycle_step();
        check_eq("random_ack_total", ack_q.size(), model_acks);

        // FAIR=0: data always wins under contention.
        nf_i_acks = 0; nf_d_acks = 0; nf_errs = 0;
        nf_mem_waitrequest = 0;
        nf_instr_read = 1; nf_data_read = 1;
        for (int c = 0; c < 40 && nf_d_acks < 4; c++) begin
            @(negedge clk);
            if (nf_instr_ack) nf_i_acks++;
            if (nf_data_ack) begin
                nf_d_acks++;
                check_eq("nf_rdata", nf_data_rdata, 32'h1234_5678);
                nf_data_read = 0;
            end else begin
                nf_data_read = 1;
            end
        end
        check_eq("nf_data_acks", nf_d_acks, 4);
        check_eq("nf_instr_acks", nf_i_acks, 0);

        // TIMEOUT=0: a long stall never aborts.
        nf_instr_read = 0; nf_data_read = 1; nf_mem_waitrequest = 1;
        nf_d_acks = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (nf_data_ack || nf_instr_ack) nf_d_acks++;
            if (nf_bus_error) nf_errs++;
        end
        check_eq("nf_stall_acks", nf_d_acks, 0);
        check_eq("nf_stall_err", nf_errs, 0);
        check_eq("nf_stall_strobe", nf_mem_read, 1'b1);
        nf_mem_waitrequest = 0; nf_mem_readdata = 32'hCAFE_0001;
        @(negedge clk);
        check_eq("nf_stall_done", {nf_data_ack, nf_mem_read}, 2'b10);
        check_eq("nf_stall_rdata", nf_data_rdata, 32'hCAFE_0001);
        nf_data_read = 0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
